// File: rtl/llc_input_arbiter.sv
// llc_input_arbiter: sequences the LLC's four inbound channels (testbench
// reset, coherence response, coherence request, DMA request) into the single
// decode slot that feeds the set-read pipeline. Fixed priority with
// anti-starvation aging for req/dma, req stall honoured, DMA bursts locked.
// Optional feature: define LLC_ARB_STATS_EN to expose grant/promotion counters.
module llc_input_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int STARVE_MAX = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rst_tb_valid,
    output logic                  rst_tb_ready,
    input  logic [DATA_WIDTH-1:0] rst_tb_data,
    input  logic                  rsp_valid,
    output logic                  rsp_ready,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic                  dma_valid,
    output logic                  dma_ready,
    input  logic [DATA_WIDTH-1:0] dma_data,
    input  logic                  dma_last,
    input  logic                  req_stall,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_src
`ifdef LLC_ARB_STATS_EN
    ,
    output logic [31:0]           stat_rst_tb,
    output logic [31:0]           stat_rsp,
    output logic [31:0]           stat_req,
    output logic [31:0]           stat_dma,
    output logic [31:0]           stat_promote
`endif
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SAT = CW'(STARVE_MAX);

    typedef enum logic {
        IDLE,
        DMA_LOCK
    } state_t;

    state_t state, state_next;

    logic [CW-1:0] req_cnt, dma_cnt;
    logic          req_elig, req_sat, dma_sat;
    logic          take;
    logic          sel_rst, sel_rsp, sel_req, sel_dma, sel_promo;
    logic          gnt_rst, gnt_rsp, gnt_req, gnt_dma, gnt_any;

    assign req_elig = req_valid & ~req_stall;
    assign req_sat  = (req_cnt == SAT);
    assign dma_sat  = (dma_cnt == SAT);

    // The slot can accept a new entry when it is empty or being drained now.
    assign take = ~out_valid | out_ready;

    // State register: reset always returns to IDLE, dropping any open burst.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state: a dma grant opens the lock unless it is the last beat.
    always_comb begin
        state_next = state;
        if (gnt_dma) state_next = dma_last ? IDLE : DMA_LOCK;
    end

    // Winner selection: rst_tb always first; lock admits only dma; otherwise
    // saturated req/dma jump above rsp (req before dma), then base order.
    always_comb begin
        sel_rst   = 1'b0;
        sel_rsp   = 1'b0;
        sel_req   = 1'b0;
        sel_dma   = 1'b0;
        sel_promo = 1'b0;
        if (rst_tb_valid) begin
            sel_rst = 1'b1;
        end else if (state == DMA_LOCK) begin
            sel_dma = dma_valid;
        end else if (req_sat && req_elig) begin
            sel_req   = 1'b1;
            sel_promo = 1'b1;
        end else if (dma_sat && dma_valid) begin
            sel_dma   = 1'b1;
            sel_promo = 1'b1;
        end else if (rsp_valid) begin
            sel_rsp = 1'b1;
        end else if (req_elig) begin
            sel_req = 1'b1;
        end else if (dma_valid) begin
            sel_dma = 1'b1;
        end
    end

    assign gnt_rst = sel_rst & take & ~rst;
    assign gnt_rsp = sel_rsp & take & ~rst;
    assign gnt_req = sel_req & take & ~rst;
    assign gnt_dma = sel_dma & take & ~rst;
    assign gnt_any = gnt_rst | gnt_rsp | gnt_req | gnt_dma;

    assign rst_tb_ready = gnt_rst;
    assign rsp_ready    = gnt_rsp;
    assign req_ready    = gnt_req;
    assign dma_ready    = gnt_dma;

    // Starvation aging: count eligible-but-ungranted cycles, clear otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_cnt <= '0;
            dma_cnt <= '0;
        end else begin
            if (req_elig && !gnt_req) begin
                if (!req_sat) req_cnt <= req_cnt + 1'b1;
            end else begin
                req_cnt <= '0;
            end
            if (dma_valid && !gnt_dma) begin
                if (!dma_sat) dma_cnt <= dma_cnt + 1'b1;
            end else begin
                dma_cnt <= '0;
            end
        end
    end

    // Output slot: load the winner, empty on a drain with nothing to load.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
        end else if (gnt_any) begin
            out_valid <= 1'b1;
            if (gnt_rst) begin
                out_data <= rst_tb_data;
                out_src  <= 2'd0;
            end else if (gnt_rsp) begin
                out_data <= rsp_data;
                out_src  <= 2'd1;
            end else if (gnt_req) begin
                out_data <= req_data;
                out_src  <= 2'd2;
            end else begin
                out_data <= dma_data;
                out_src  <= 2'd3;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef LLC_ARB_STATS_EN
    // Grant statistics; promoted grants are those taken via the aging path.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rst_tb  <= '0;
            stat_rsp     <= '0;
            stat_req     <= '0;
            stat_dma     <= '0;
            stat_promote <= '0;
        end else begin
            if (gnt_rst) stat_rst_tb <= stat_rst_tb + 32'd1;
            if (gnt_rsp) stat_rsp    <= stat_rsp + 32'd1;
            if (gnt_req) stat_req    <= stat_req + 32'd1;
            if (gnt_dma) stat_dma    <= stat_dma + 32'd1;
            if (gnt_any && sel_promo) stat_promote <= stat_promote + 32'd1;
        end
    end
`else
    logic unused_promo;
    assign unused_promo = sel_promo;
`endif

endmodule

// File: tb/tb_llc_input_arbiter.sv
// tb_llc_input_arbiter: directed self-checking bench for llc_input_arbiter.
// Inputs change 1 time unit after the rising edge; combinational readies and
// registered slot outputs are both sampled 2 time units after the edge.
module tb_llc_input_arbiter;

    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          rst_tb_valid, rsp_valid, req_valid, dma_valid;
    logic          rst_tb_ready, rsp_ready, req_ready, dma_ready;
    logic [DW-1:0] rst_tb_data, rsp_data, req_data, dma_data;
    logic          dma_last, req_stall;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_src;
`ifdef LLC_ARB_STATS_EN
    logic [31:0]   stat_rst_tb, stat_rsp, stat_req, stat_dma, stat_promote;
`endif

    int checks = 0;
    int passes = 0;

    llc_input_arbiter #(.DATA_WIDTH(DW), .STARVE_MAX(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .rst_tb_valid (rst_tb_valid),
        .rst_tb_ready (rst_tb_ready),
        .rst_tb_data  (rst_tb_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .dma_valid    (dma_valid),
        .dma_ready    (dma_ready),
        .dma_data     (dma_data),
        .dma_last     (dma_last),
        .req_stall    (req_stall),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_src      (out_src)
`ifdef LLC_ARB_STATS_EN
        ,
        .stat_rst_tb  (stat_rst_tb),
        .stat_rsp     (stat_rsp),
        .stat_req     (stat_req),
        .stat_dma     (stat_dma),
        .stat_promote (stat_promote)
`endif
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [DW-1:0] got,
                               input logic [DW-1:0] exp);
        checks++;
        if (got !== exp)
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            passes++;
    endtask

    // Readies packed as {rst_tb, rsp, req, dma}.
    task automatic checkReadies(input string tag, input logic [3:0] exp);
        checkOutput(tag, DW'({rst_tb_ready, rsp_ready, req_ready, dma_ready}), DW'(exp));
    endtask

    task automatic checkSlot(input string tag, input logic v, input logic [1:0] src,
                             input logic [DW-1:0] data);
        checkOutput({tag, "_valid"}, DW'(out_valid), DW'(v));
        checkOutput({tag, "_src"}, DW'(out_src), DW'(src));
        checkOutput({tag, "_data"}, out_data, data);
    endtask

    task automatic applyStimulus(input logic rt, input logic rs, input logic rq,
                                 input logic stall, input logic dm, input logic last,
                                 input logic ordy);
        rst_tb_valid = rt;
        rsp_valid    = rs;
        req_valid    = rq;
        req_stall    = stall;
        dma_valid    = dm;
        dma_last     = last;
        out_ready    = ordy;
        #1;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst         = 1'b1;
        rst_tb_data = 128'h1111;
        rsp_data    = 128'h2222;
        req_data    = 128'h3333;
        dma_data    = 128'h4441;
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        tick;
        tick;

        // Reset state and readies held low while rst is high.
        applyStimulus(1, 1, 1, 0, 1, 1, 1);
        checkReadies("rst_readies", 4'b0000);
        checkSlot("rst_slot", 1'b0, 2'd0, 128'h0);

        // All four valid: rst_tb, rsp, req, dma one per cycle.
        rst = 1'b0;
        #1;
        checkReadies("all4_c0", 4'b1000);
        tick;
        checkSlot("all4_s0", 1'b1, 2'd0, 128'h1111);
        applyStimulus(0, 1, 1, 0, 1, 1, 1);
        checkReadies("all4_c1", 4'b0100);
        tick;
        checkSlot("all4_s1", 1'b1, 2'd1, 128'h2222);
        applyStimulus(0, 0, 1, 0, 1, 1, 1);
        checkReadies("all4_c2", 4'b0010);
        tick;
        checkSlot("all4_s2", 1'b1, 2'd2, 128'h3333);
        applyStimulus(0, 0, 0, 0, 1, 1, 1);
        checkReadies("all4_c3", 4'b0001);
        tick;
        checkSlot("all4_s3", 1'b1, 2'd3, 128'h4441);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkReadies("drain_none", 4'b0000);
        tick;
        checkOutput("drain_empty", DW'(out_valid), DW'(1'b0));

        // Starvation: rsp for 15 cycles, req promoted on cycle 16.
        applyStimulus(0, 1, 1, 0, 0, 0, 1);
        for (int i = 1; i <= 15; i++) begin
            checkReadies($sformatf("starve_c%0d", i), 4'b0100);
            tick;
        end
        checkReadies("starve_c16", 4'b0010);
        tick;
        checkSlot("starve_s16", 1'b1, 2'd2, 128'h3333);
        checkReadies("starve_c17", 4'b0100);
        tick;
        checkReadies("starve_c18", 4'b0100);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        tick;

        // DMA burst of 3 beats with rsp pending and rst_tb mid-burst.
        dma_data = 128'hD1;
        applyStimulus(0, 0, 0, 0, 1, 0, 1);
        checkReadies("burst_b1", 4'b0001);
        tick;
        checkSlot("burst_s1", 1'b1, 2'd3, 128'hD1);
        dma_data = 128'hD2;
        applyStimulus(1, 1, 0, 0, 1, 0, 1);
        checkReadies("burst_rst", 4'b1000);
        tick;
        checkSlot("burst_srst", 1'b1, 2'd0, 128'h1111);
        applyStimulus(0, 1, 0, 0, 1, 0, 1);
        checkReadies("burst_b2", 4'b0001);
        tick;
        checkSlot("burst_s2", 1'b1, 2'd3, 128'hD2);
        dma_data = 128'hD3;
        applyStimulus(0, 1, 0, 0, 1, 1, 1);
        checkReadies("burst_b3", 4'b0001);
        tick;
        checkSlot("burst_s3", 1'b1, 2'd3, 128'hD3);
        applyStimulus(0, 1, 0, 0, 0, 0, 1);
        checkReadies("burst_rsp", 4'b0100);
        tick;
        checkSlot("burst_srsp", 1'b1, 2'd1, 128'h2222);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        tick;

        // Stalled req never granted or aged; dma single beats win meanwhile.
        dma_data = 128'h4441;
        applyStimulus(0, 0, 1, 1, 1, 1, 1);
        for (int i = 0; i < 40; i++) begin
            checkReadies($sformatf("stall_c%0d", i), 4'b0001);
            tick;
        end
        applyStimulus(0, 1, 1, 0, 1, 1, 1);
        checkReadies("stall_drop_rsp", 4'b0100);
        tick;
        applyStimulus(0, 0, 1, 0, 1, 1, 1);
        checkReadies("stall_drop_req", 4'b0010);
        tick;
        checkSlot("stall_sreq", 1'b1, 2'd2, 128'h3333);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        tick;

        // Backpressure: entry held stable for 5 cycles, reload on release.
        applyStimulus(0, 1, 0, 0, 0, 0, 1);
        tick;
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            checkReadies($sformatf("hold_rdy%0d", i), 4'b0000);
            checkSlot($sformatf("hold_s%0d", i), 1'b1, 2'd1, 128'h2222);
            tick;
        end
        rsp_data = 128'h2223;
        applyStimulus(0, 1, 1, 0, 0, 0, 1);
        checkReadies("hold_release", 4'b0100);
        tick;
        checkSlot("hold_reload", 1'b1, 2'd1, 128'h2223);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        tick;
        checkOutput("hold_empty", DW'(out_valid), DW'(1'b0));

        // Reset in DMA_LOCK with the slot full.
        dma_data = 128'hE1;
        applyStimulus(0, 0, 0, 0, 1, 0, 1);
        tick;
        checkSlot("lock_s", 1'b1, 2'd3, 128'hE1);
        rst = 1'b1;
        applyStimulus(0, 1, 0, 0, 1, 0, 1);
        checkReadies("lockrst_rdy", 4'b0000);
        tick;
        checkSlot("lockrst_slot", 1'b0, 2'd0, 128'h0);
        rst = 1'b0;
        #1;
        checkReadies("lockrst_idle", 4'b0100);
        tick;
        checkSlot("lockrst_rsp", 1'b1, 2'd1, 128'h2223);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/llc_input_arbiter.md
Name: llc_input_arbiter

Overview:
- Sequences the LLC's four inbound channels (testbench reset, coherence response, coherence request, DMA request) into the single decode slot that feeds the set-read pipeline.
- Applies fixed priority with anti-starvation aging, honours the request stall, and locks onto DMA bursts.
- Registers the winner into a one-entry output slot with valid/ready handshake.

Parameters:
- DATA_WIDTH, 128, payload width of every input channel and of the output.
- STARVE_MAX, 15, consecutive valid-but-ungranted cycles before req or dma_req is promoted above rsp.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rst_tb_valid / rst_tb_ready / rst_tb_data  in/out/in  1/1/DATA_WIDTH  testbench reset channel
- rsp_valid / rsp_ready / rsp_data  in/out/in  1/1/DATA_WIDTH  coherence response channel
- req_valid / req_ready / req_data  in/out/in  1/1/DATA_WIDTH  coherence request channel
- dma_valid / dma_ready / dma_data / dma_last  in/out/in/in  1/1/DATA_WIDTH/1  DMA request channel; dma_last marks the final beat of a burst
- req_stall  in  1  blocks the req channel (set conflict pending)
- out_valid  out  1  decode slot holds an entry
- out_ready  in  1  downstream accepts the slot
- out_data  out  DATA_WIDTH  winning payload
- out_src  out  2  source of the entry: 0 rst_tb, 1 rsp, 2 req, 3 dma

Behaviour:
- Interface: one clock `clk`; `rst` is synchronous, active-high, sampled on posedge clk.
- Reset values:
  - out_valid=0, out_data=0, out_src=0.
  - FSM in IDLE; starvation counters 0.
  - All *_ready=0 while rst=1.
- Slot can accept (`take`) = !out_valid | out_ready.
  - At most one input ready per cycle.
  - An input's ready is asserted only if it is the winner and take=1.
  - Ready never depends combinationally on out_data.
- Latency: input handshake in cycle N gives out_valid=1 with that payload in cycle N+1.
  - Back-to-back throughput is 1/cycle when out_ready stays high.
  - Slot contents hold stable while out_valid & !out_ready.
- Eligibility:
  - req is eligible only if req_valid & !req_stall.
  - Every other channel is eligible if its valid is high.
- Priority in IDLE:
  - Base order: rst_tb > rsp > req > dma.
  - A saturated counter (==STARVE_MAX) promotes its channel above rsp but never above rst_tb.
  - If both req and dma are saturated, req wins.
- Starvation counters (req, dma), width $clog2(STARVE_MAX+1), saturating:
  - Increment on a cycle where the channel is eligible but not granted.
  - Clear on grant or when the channel is not eligible.
  - Stalled req cycles therefore do not age.
- FSM, states IDLE and DMA_LOCK:
  - IDLE -> DMA_LOCK on a dma grant with dma_last=0.
  - In DMA_LOCK, only dma may be granted; rst_tb still wins if valid. A rst_tb grant does not leave the lock.
  - DMA_LOCK -> IDLE on a dma grant with dma_last=1.
  - A dma grant with dma_last=1 in IDLE stays in IDLE.
- Simultaneous events:
  - A grant and a slot drain in the same cycle: the slot is overwritten with the new winner and out_valid stays 1.
  - No eligible input and a drain: out_valid falls to 0 next cycle.
- Reset mid-burst: rst forces IDLE and clears the slot. Any in-flight payload is dropped; no replay.
- Payload is passed unmodified. out_src is encoded per the table above.

Optional Feature:
- Macro: LLC_ARB_STATS_EN.
- When defined:
  - Four 32-bit wrapping grant counters (stat_rst_tb, stat_rsp, stat_req, stat_dma) are exposed as outputs.
  - A 32-bit stat_promote counter increments on every grant won through starvation promotion.
  - All counters clear on rst.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- All four valid in one cycle, out_ready=1 -> grants over 4 cycles in order rst_tb, rsp, req, dma; out_src 0,1,2,3 each one cycle after its handshake.
- rsp held valid continuously, req valid, STARVE_MAX=15 -> req granted on cycle 16 ahead of rsp, its counter returns to 0, then rsp resumes.
- dma burst of 3 beats (dma_last on beat 3) with rsp valid throughout -> the 3 dma beats are consecutive and rsp is granted the cycle after beat 3; rst_tb asserted mid-burst is granted and the lock persists.
- req_valid=1 with req_stall=1 for 40 cycles and dma valid -> req never ready, dma granted, req counter stays 0; req granted the cycle stall drops.
- out_ready=0 for 5 cycles with an entry held -> out_data/out_src stable, all *_ready=0; when out_ready rises, the next winner is loaded the same cycle.
- rst asserted in DMA_LOCK with out_valid=1 -> next cycle out_valid=0, FSM in IDLE, all readies 0 during rst; rsp granted first cycle after release.
